dff_pipe: RTL and testbench

Parametrised successor to the single D flip-flop: a DEPTH-stage, WIDTH-bit elastic register pipeline with valid/ready handshake, back-pressure, synchronous flush and occupancy count.
Used wherever the datapath needs a multi-cycle, stall-tolerant delay between producer and consumer.
Sustains one transfer per cycle when unstalled.

---
 rtl/dff_pipe_pkg.sv | 18 +
 rtl/dff_pipe_if.sv | 29 ++
 rtl/dff_pipe_stage.sv | 41 ++++
 rtl/dff_pipe.sv | 117 +++++++++++
 tb/tb_dff_pipe.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/dff_pipe_pkg.sv
// Shared types and constants for the dff_pipe elastic register pipeline.
package dff_pipe_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Occupancy counter width: must represent 0..DEPTH inclusive.
    function automatic int clog2p1(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [DEF_WIDTH-1:0] data;
        logic                 parity;
    } stage_t;

endpackage

// File: rtl/dff_pipe_if.sv
// Handshake bundle for dff_pipe: producer side, consumer side, flush and occupancy.
interface dff_pipe_if
    import dff_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int OW = clog2p1(DEPTH);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic [OW-1:0]    occupancy;

    modport master (
        output flush, in_valid, d, out_ready,
        input  in_ready, out_valid, q, occupancy
    );

    modport slave (
        input  flush, in_valid, d, out_ready,
        output in_ready, out_valid, q, occupancy
    );

endinterface

// File: rtl/dff_pipe_stage.sv
// One elastic pipeline stage: loads valid+data when ld, otherwise holds; sync clear.
module dff_pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             ld,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] q_out
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ld) begin
            valid_d = valid_in;
            data_d  = d_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_out = valid_q;
    assign q_out     = data_q;

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage elastic register pipeline with valid/ready, flush and occupancy.
// Optional per-stage even parity with parity_err output: define DFF_PIPE_PARITY_EN.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic       clk,
    input  logic       reset,
`ifdef DFF_PIPE_PARITY_EN
    output logic       parity_err,
`endif
    dff_pipe_if.slave  bus
);

    localparam int OW = clog2p1(DEPTH);

`ifdef DFF_PIPE_PARITY_EN
    localparam int              SW     = WIDTH + 1;
    localparam logic [SW-1:0]   RST_SW = {^RESET_VAL, RESET_VAL};
`else
    localparam int              SW     = WIDTH;
    localparam logic [SW-1:0]   RST_SW = RESET_VAL;
`endif

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] rdy;
    logic [SW-1:0]    data_s [DEPTH];
    logic [SW-1:0]    d_ext;
    logic             in_xfer, out_xfer;
    logic [OW-1:0]    occ_d, occ_q;

`ifdef DFF_PIPE_PARITY_EN
    assign d_ext = {^bus.d, bus.d};
`else
    assign d_ext = bus.d;
`endif

    // Unrolled ready chain: a stage may load if any stage at or after it is empty.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        assign rdy[i] = bus.out_ready || !(&vld[DEPTH-1:i]);

        if (i == 0) begin : g_first
            dff_pipe_stage #(.WIDTH(SW), .RESET_VAL(RST_SW)) u_stage (
                .clk       (clk),
                .reset     (reset),
                .clr       (bus.flush),
                .ld        (rdy[i]),
                .valid_in  (bus.in_valid),
                .d_in      (d_ext),
                .valid_out (vld[i]),
                .q_out     (data_s[i])
            );
        end else begin : g_next
            dff_pipe_stage #(.WIDTH(SW), .RESET_VAL(RST_SW)) u_stage (
                .clk       (clk),
                .reset     (reset),
                .clr       (bus.flush),
                .ld        (rdy[i]),
                .valid_in  (vld[i-1]),
                .d_in      (data_s[i-1]),
                .valid_out (vld[i]),
                .q_out     (data_s[i])
            );
        end
    end

    assign bus.in_ready  = rdy[0] && !bus.flush && !reset;
    assign bus.out_valid = vld[DEPTH-1];
    assign bus.q         = data_s[DEPTH-1][WIDTH-1:0];
    assign bus.occupancy = occ_q;

    assign in_xfer  = bus.in_valid && bus.in_ready;
    assign out_xfer = vld[DEPTH-1] && bus.out_ready;

    always_comb begin
        occ_d = occ_q;
        if (in_xfer && !out_xfer) begin
            occ_d = occ_q + 1'b1;
        end else if (!in_xfer && out_xfer) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    a_occ_matches_valid: assert property (@(posedge clk) disable iff (reset)
        occ_q == OW'($countones(vld)));

`ifdef DFF_PIPE_PARITY_EN
    logic parity_err_d, parity_err_q;

    // Stored word is {parity, data}; its XOR is zero when intact.
    always_comb begin
        parity_err_d = vld[DEPTH-1] && (^data_s[DEPTH-1] != 1'b0);
    end

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe (WIDTH=8, DEPTH=4, RESET_VAL=0x3C).
module tb_dff_pipe;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    dff_pipe_if #(.WIDTH(8), .DEPTH(4)) bus ();

`ifdef DFF_PIPE_PARITY_EN
    logic parity_err;
`endif

    dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h3C)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef DFF_PIPE_PARITY_EN
        .parity_err (parity_err),
`endif
        .bus        (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.d         = 8'h00;
        bus.out_ready = 1'b0;

        // reset state
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_q", 32'(bus.q), 'h3C);
        check("rst_occ", 32'(bus.occupancy), 0);
        check("rst_in_ready", 32'(bus.in_ready), 0);

        // streaming 0x01..0x08, out_ready held high
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.d = 8'(k + 1);
            #1;
            check("stream_in_ready", 32'(bus.in_ready), 1);
            tick();
            if (k >= 3) begin
                check("stream_out_valid", 32'(bus.out_valid), 1);
                check("stream_q", 32'(bus.q), 32'(k - 2));
                check("stream_occ", 32'(bus.occupancy), 4);
            end else begin
                check("stream_fill_valid", 32'(bus.out_valid), 0);
                check("stream_fill_occ", 32'(bus.occupancy), 32'(k + 1));
            end
        end
        bus.in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("drain_q", 32'(bus.q), 32'(6 + j));
            check("drain_occ", 32'(bus.occupancy), 32'(3 - j));
        end
        tick();
        check("drain_empty", 32'(bus.out_valid), 0);
        check("drain_occ0", 32'(bus.occupancy), 0);

        // full stall then release
        bus.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.in_valid = 1'b1;
            bus.d = 8'(8'hA0 + k);
            #1;
            check("stall_in_ready", 32'(bus.in_ready), (k < 4) ? 1 : 0);
            tick();
            if (k >= 3) check("stall_q_held", 32'(bus.q), 'hA0);
        end
        check("stall_occ", 32'(bus.occupancy), 4);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("release_valid", 32'(bus.out_valid), 1);
            check("release_q", 32'(bus.q), 32'('hA0 + i));
            tick();
        end
        check("release_empty", 32'(bus.out_valid), 0);
        check("release_occ0", 32'(bus.occupancy), 0);

        // bubbles: in_valid 1,0,1,0
        begin
            logic [6:0] exp_v;
            int         exp_occ [7];
            exp_v = 7'b0101000;
            exp_occ = '{1, 1, 2, 2, 1, 1, 0};
            for (int t = 0; t < 7; t++) begin
                bus.in_valid = (t < 4) && (t % 2 == 0);
                bus.d = 8'(8'hB0 + t);
                tick();
                check("bubble_valid", 32'(bus.out_valid), 32'(exp_v[t]));
                check("bubble_occ", 32'(bus.occupancy), 32'(exp_occ[t]));
                if (t == 3) check("bubble_q0", 32'(bus.q), 'hB0);
                if (t == 5) check("bubble_q2", 32'(bus.q), 'hB2);
            end
        end

        // flush mid-stream
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.d = 8'(8'hC1 + k);
            tick();
        end
        check("preflush_occ", 32'(bus.occupancy), 3);
        bus.flush = 1'b1;
        bus.d = 8'h55;
        #1;
        check("flush_in_ready", 32'(bus.in_ready), 0);
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("flush_valid", 32'(bus.out_valid), 0);
        check("flush_occ", 32'(bus.occupancy), 0);
        check("flush_q", 32'(bus.q), 'h3C);
        for (int j = 0; j < 5; j++) begin
            tick();
            check("flush_no_55", 32'(bus.out_valid), 0);
        end

        // simultaneous push/pop when full
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.d = 8'(8'hD0 + k);
            tick();
        end
        check("full_occ", 32'(bus.occupancy), 4);
        check("full_q", 32'(bus.q), 'hD0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.d = 8'(8'hD4 + k);
            #1;
            check("pushpop_in_ready", 32'(bus.in_ready), 1);
            tick();
            check("pushpop_occ", 32'(bus.occupancy), 4);
            check("pushpop_q", 32'(bus.q), 32'('hD1 + k));
        end
        bus.in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("pushpop_drain_q", 32'(bus.q), 32'('hD3 + j));
        end
        tick();
        check("pushpop_empty", 32'(bus.out_valid), 0);

        // reset mid-stream
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.d = 8'hF0;
        tick();
        bus.d = 8'hF1;
        tick();
        check("midrst_pre_occ", 32'(bus.occupancy), 2);
        reset = 1'b1;
        #1;
        check("midrst_in_ready", 32'(bus.in_ready), 0);
        tick();
        check("midrst_occ", 32'(bus.occupancy), 0);
        check("midrst_valid", 32'(bus.out_valid), 0);
        check("midrst_q", 32'(bus.q), 'h3C);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("midrst_stays_empty", 32'(bus.occupancy), 0);

`ifdef DFF_PIPE_PARITY_EN
        // corrupt the word sitting in the last stage
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.d = 8'(8'hE0 + k);
            tick();
        end
        bus.in_valid = 1'b0;
        check("par_clean", 32'(parity_err), 0);
        dut.g_stage[3].g_next.u_stage.data_q[0] = ~dut.g_stage[3].g_next.u_stage.data_q[0];
        bus.out_ready = 1'b1;
        tick();
        check("par_err_set", 32'(parity_err), 1);
        tick();
        check("par_err_one_cycle", 32'(parity_err), 0);
        tick();
        tick();
        check("par_err_drain", 32'(parity_err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
